// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM balance-store arbiter: opcodes,
// controller states and the result record produced by the execute step.
package atm_pkg;

    localparam int DATA_W = 32;
    localparam int DEF_NUM_ACC = 10;
    localparam logic [DATA_W-1:0] DEF_INIT_BALANCE = 32'd1000;

    typedef enum logic [1:0] {
        OP_BALANCE  = 2'b00,
        OP_WITHDRAW = 2'b01,
        OP_DEPOSIT  = 2'b10,
        OP_RSVD     = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef struct packed {
        logic              ok;
        logic [DATA_W-1:0] bal;
    } result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search begins one past the last granted terminal
// and wraps, returning the first requester as one-hot and as an index.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int   k;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = int'(last) + i;
            if (k >= N) k = k - N;
            if (!found && req[k[ID_W-1:0]]) begin
                grant[k[ID_W-1:0]] = 1'b1;
                idx                = k[ID_W-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Multi-terminal ATM front end: arbitrates terminals round-robin and runs one
// read-modify-write on a shared balance array per granted request.
module bank_arbiter
    import atm_pkg::*;
#(
    parameter int                NUM_TERM     = 4,
    parameter int                NUM_ACC      = DEF_NUM_ACC,
    parameter logic [DATA_W-1:0] INIT_BALANCE = DEF_INIT_BALANCE,
    localparam int               ID_W         = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_TERM-1:0]      req,
    input  logic [2*NUM_TERM-1:0]    op,
    input  logic [4*NUM_TERM-1:0]    acc,
    input  logic [32*NUM_TERM-1:0]   amount,
    output logic [NUM_TERM-1:0]      ack,
    output logic                     success,
    output logic [DATA_W-1:0]        balance_out,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic [2:0]               state
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_EXEC  = ST_EXEC;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_RESP  = ST_RESP;

    logic [ID_W-1:0]     last_grant;
    logic [NUM_TERM-1:0] win_oh;
    logic [ID_W-1:0]     win_idx;
    logic [NUM_TERM-1:0] gnt_l;

    op_e                 op_l;
    logic [3:0]          acc_l;
    logic [DATA_W-1:0]   amt_l;
    logic [DATA_W-1:0]   work;
    result_t             res;
    logic                acc_ok;
    logic                commit;

    logic [DATA_W-1:0]   mem [NUM_ACC];

    // Applies one opcode to a loaded balance; an out-of-range account reports
    // zero, and every failure leaves the balance as it was.
    function automatic result_t exec_txn(input op_e o, input logic valid,
                                         input logic [DATA_W-1:0] bal,
                                         input logic [DATA_W-1:0] amt);
        result_t       r;
        logic [DATA_W:0] sum;
        sum   = {1'b0, bal} + {1'b0, amt};
        r.ok  = 1'b0;
        r.bal = bal;
        if (!valid) begin
            r.bal = '0;
        end else begin
            case (o)
                OP_BALANCE: r.ok = 1'b1;
                OP_WITHDRAW: begin
                    if (amt <= bal) begin
                        r.ok  = 1'b1;
                        r.bal = bal - amt;
                    end
                end
                OP_DEPOSIT: begin
                    if (!sum[DATA_W]) begin
                        r.ok  = 1'b1;
                        r.bal = sum[DATA_W-1:0];
                    end
                end
                default: r.ok = 1'b0;
            endcase
        end
        return r;
    endfunction

    rr_arbiter #(
        .N    (NUM_TERM),
        .ID_W (ID_W)
    ) u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (win_oh),
        .idx   (win_idx)
    );

    assign acc_ok = int'(acc_l) < NUM_ACC;
    assign busy   = (state != S_IDLE);
    assign commit = res.ok && acc_ok && (op_l == OP_WITHDRAW || op_l == OP_DEPOSIT);

    // Control: sequencing, grant bookkeeping and the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(NUM_TERM - 1);
            grant_id    <= '0;
            gnt_l       <= '0;
            ack         <= '0;
            success     <= 1'b0;
            balance_out <= '0;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant_id   <= win_idx;
                        last_grant <= win_idx;
                        gnt_l      <= win_oh;
                        state      <= S_READ;
                    end
                end
                S_READ:  state <= S_EXEC;
                S_EXEC:  state <= S_WRITE;
                S_WRITE: begin
                    ack         <= gnt_l;
                    success     <= res.ok;
                    balance_out <= res.bal;
                    state       <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: latched request fields, loaded balance and execute result.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && |req) begin
            op_l  <= op_e'(op[2*win_idx +: 2]);
            acc_l <= acc[4*win_idx +: 4];
            amt_l <= amount[32*win_idx +: 32];
        end
        if (state == S_READ) begin
            work <= acc_ok ? mem[acc_l] : '0;
        end
        if (state == S_EXEC) begin
            res <= exec_txn(op_l, acc_ok, work, amt_l);
        end
    end

    // Balance store; a reset mid-transaction lands before WRITE and so drops the commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                mem[i] <= INIT_BALANCE;
            end
        end else if (state == S_WRITE && commit) begin
            mem[acc_l] <= res.bal;
        end
    end

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: directed vector table, reset-abort and contention
// sequences, then random multi-terminal batches against a balance-array model.
module tb_bank_arbiter;

    localparam int NT = 4;
    localparam int NA = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [NT-1:0]  req;
    logic [2*NT-1:0]  op;
    logic [4*NT-1:0]  acc;
    logic [32*NT-1:0] amount;
    logic [NT-1:0]  ack;
    logic           success;
    logic [31:0]    balance_out;
    logic [1:0]     grant_id;
    logic           busy;
    logic [2:0]     state;

    bank_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op          (op),
        .acc         (acc),
        .amount      (amount),
        .ack         (ack),
        .success     (success),
        .balance_out (balance_out),
        .grant_id    (grant_id),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: plain balance array plus the last-served terminal.
    longint m_bal[NA];
    int     m_last;

    function automatic void m_reset();
        for (int i = 0; i < NA; i++) m_bal[i] = 1000;
        m_last = NT - 1;
    endfunction

    function automatic void m_exec(input int o, input int a, input longint amt,
                                   output int ok, output longint bal);
        ok  = 0;
        bal = 0;
        if (a < NA) begin
            bal = m_bal[a];
            case (o)
                0: ok = 1;
                1: if (amt <= bal) begin ok = 1; bal = bal - amt; end
                2: if (bal + amt <= 64'hFFFF_FFFF) begin ok = 1; bal = bal + amt; end
                default: ok = 0;
            endcase
            if (ok == 1) m_bal[a] = bal;
        end
    endfunction

    int     b_op [NT];
    int     b_acc[NT];
    longint b_amt[NT];
    int     obs_term[$];
    int     obs_ok[$];
    longint obs_bal[$];

    // Presents every terminal in mask at once and checks each ack against the model.
    task automatic run_batch(input logic [NT-1:0] mask);
        int     exp_t[$];
        int     exp_ok[$];
        longint exp_b[$];
        int     ok, n, cyc, prev, k;
        longint bal;
        for (int j = 1; j <= NT; j++) begin
            k = (m_last + j) % NT;
            if (mask[k]) begin
                m_exec(b_op[k], b_acc[k], b_amt[k], ok, bal);
                exp_t.push_back(k);
                exp_ok.push_back(ok);
                exp_b.push_back(bal);
            end
        end
        if (exp_t.size() > 0) m_last = exp_t[exp_t.size()-1];
        obs_term.delete();
        obs_ok.delete();
        obs_bal.delete();
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
            op[2*t +: 2]   = 2'(b_op[t]);
            acc[4*t +: 4]  = 4'(b_acc[t]);
            amount[32*t +: 32] = 32'(b_amt[t]);
        end
        req  = mask;
        n    = 0;
        cyc  = 0;
        prev = 0;
        while (n < exp_t.size() && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack != '0) begin
                check("ack_vector", ack, 1 << exp_t[n]);
                check("grant_id", grant_id, exp_t[n]);
                check("success", success, exp_ok[n]);
                check("balance_out", balance_out, exp_b[n]);
                if (n == 0) check("latency", cyc, 4);
                else check("spacing", cyc - prev, 5);
                obs_term.push_back(int'(grant_id));
                obs_ok.push_back(int'(success));
                obs_bal.push_back(longint'(balance_out));
                prev = cyc;
                req  = req & ~ack;
                n++;
            end
        end
        n_checks++;
        if (n == exp_t.size()) n_pass++;
        else $display("FAIL batch_timeout: got %0d acks, expected %0d", n, exp_t.size());
        req = '0;
        @(posedge clk);
        #1;
        check("ack_one_cycle", ack, 0);
        check("idle_after_resp", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        int     term;
        int     op;
        int     acc;
        longint amt;
        int     ok;
        longint bal;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int seen;
        logic [NT-1:0] mask;
        rst = 1'b1;
        req = '0;
        op  = '0;
        acc = '0;
        amount = '0;
        for (int t = 0; t < NT; t++) begin b_op[t] = 0; b_acc[t] = 0; b_amt[t] = 0; end

        tbl[0]  = '{0, 0,  3, 0,            1, 1000};
        tbl[1]  = '{1, 1,  2, 300,          1, 700};
        tbl[2]  = '{1, 0,  2, 0,            1, 700};
        tbl[3]  = '{2, 1,  5, 1001,         0, 1000};
        tbl[4]  = '{2, 0,  5, 0,            1, 1000};
        tbl[5]  = '{3, 2,  1, 64'hFFFF_FFFF, 0, 1000};
        tbl[6]  = '{3, 0,  1, 0,            1, 1000};
        tbl[7]  = '{0, 0, 12, 0,            0, 0};
        tbl[8]  = '{1, 3,  6, 5,            0, 1000};
        tbl[9]  = '{2, 2,  7, 0,            1, 1000};
        tbl[10] = '{0, 1,  9, 1000,         1, 0};
        tbl[11] = '{0, 0,  9, 0,            1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_success", success, 0);
        check("rst_balance", balance_out, 0);
        check("rst_grant_id", grant_id, 0);
        rst = 1'b0;
        m_reset();

        for (int i = 0; i < 12; i++) begin
            b_op[tbl[i].term]  = tbl[i].op;
            b_acc[tbl[i].term] = tbl[i].acc;
            b_amt[tbl[i].term] = tbl[i].amt;
            run_batch(NT'(1 << tbl[i].term));
            check($sformatf("tbl%0d_acks", i), obs_ok.size(), 1);
            if (obs_ok.size() > 0) begin
                check($sformatf("tbl%0d_ok", i), obs_ok[0], tbl[i].ok);
                check($sformatf("tbl%0d_bal", i), obs_bal[0], tbl[i].bal);
            end
        end

        // Reset while a withdrawal sits in EXEC: nothing commits, nothing acks.
        @(negedge clk);
        op[1:0]   = 2'b01;
        acc[3:0]  = 4'd4;
        amount[31:0] = 32'd500;
        req       = 4'b0001;
        @(posedge clk);
        #1;
        check("abort_in_read", state, 1);
        @(posedge clk);
        #1;
        check("abort_in_exec", state, 2);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack != '0) seen++;
        end
        check("abort_no_ack", seen, 0);
        b_op[0] = 0; b_acc[0] = 4; b_amt[0] = 0;
        run_batch(4'b0001);
        check("abort_acc4_bal", (obs_bal.size() > 0) ? obs_bal[0] : -1, 1000);
        b_op[1] = 0; b_acc[1] = 2; b_amt[1] = 0;
        run_batch(4'b0010);
        check("reset_restores_acc2", (obs_bal.size() > 0) ? obs_bal[0] : -1, 1000);

        // Four simultaneous deposits to one account, served in round-robin order.
        do_reset();
        for (int t = 0; t < NT; t++) begin b_op[t] = 2; b_acc[t] = 0; b_amt[t] = 10; end
        run_batch(4'b1111);
        check("contend_acks", obs_term.size(), 4);
        for (int i = 0; i < obs_term.size(); i++) begin
            check($sformatf("contend_term%0d", i), obs_term[i], i);
            check($sformatf("contend_bal%0d", i), obs_bal[i], 1010 + 10 * i);
        end

        // Random batches on a few hot accounts plus some invalid ones.
        do_reset();
        for (int r = 0; r < 40; r++) begin
            mask = NT'($urandom_range(1, (1 << NT) - 1));
            for (int t = 0; t < NT; t++) begin
                b_op[t]  = $urandom_range(0, 3);
                b_acc[t] = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0: b_amt[t] = $urandom_range(0, 1500);
                    1: b_amt[t] = longint'($urandom);
                    2: b_amt[t] = 64'hFFFF_FFFF - $urandom_range(0, 3000);
                    default: b_amt[t] = $urandom_range(0, 200);
                endcase
            end
            run_batch(mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter NUM_TERM, default 4, number of ATM terminals sharing the balance store.
REQ-002 Parameter NUM_ACC, default 10, number of account balance entries.
REQ-003 Parameter INIT_BALANCE, default 1000, balance loaded into every entry on reset.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  NUM_TERM  per-terminal transaction request, level.
REQ-007 op  in  2*NUM_TERM  per-terminal opcode, flattened: terminal k at bits [2k+1:2k].
REQ-008 acc  in  4*NUM_TERM  per-terminal account index, flattened: terminal k at bits [4k+3:4k].
REQ-009 amount  in  32*NUM_TERM  per-terminal unsigned amount, flattened: terminal k at bits [32k+31:32k].
REQ-010 ack  out  NUM_TERM  one-cycle completion pulse to the served terminal.
REQ-011 success  out  1  result of the completed transaction; valid while ack is high, held until the next ack.
REQ-012 balance_out  out  32  account balance after the completed transaction; same validity as success.
REQ-013 grant_id  out  2  index of the terminal currently or last served.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 state  out  3  current FSM state encoding, for debug.

Function
REQ-016 Opcodes: 00 BALANCE, 01 WITHDRAW, 10 DEPOSIT, 11 reserved.
REQ-017 FSM states IDLE -> READ -> EXEC -> WRITE -> RESP -> IDLE; every non-IDLE state lasts exactly one cycle.
REQ-018 IDLE with any req bit high: select a winner round-robin, latch its op/acc/amount and grant_id, and go to READ; with no req high, stay in IDLE.
REQ-019 Round-robin search starts at (last granted + 1) mod NUM_TERM; last granted updates only at grant.
REQ-020 READ: load the addressed balance into a working register.
REQ-021 EXEC, BALANCE: success=1, no change.
REQ-022 EXEC, WITHDRAW: if amount <= balance, new balance = balance - amount and success=1; else success=0 and balance unchanged.
REQ-023 EXEC, DEPOSIT: compute a 33-bit sum; on carry out, success=0 and balance unchanged; else new balance = sum and success=1.
REQ-024 EXEC, reserved opcode: success=0, no change.
REQ-025 Latched acc >= NUM_ACC: success=0, balance_out=0, no memory access.
REQ-026 WRITE: commit the new balance only for a successful WITHDRAW or DEPOSIT.
REQ-027 RESP: ack[grant_id]=1 for exactly one cycle; success and balance_out update in the same cycle.
REQ-028 Latency: req sampled in IDLE at cycle t gives ack at cycle t+4; sustained throughput is one transaction per 5 cycles.
REQ-029 Terminal handshake: hold req and fields stable until ack; a req still high in the cycle after ack is a new request.
REQ-030 Fields are latched at grant; a req dropped before ack does not abort the transaction.
REQ-031 Simultaneous requests to the same account are serialized; each sees the previous committed balance.
REQ-032 All terminals share success and balance_out; only the acked terminal may consume them.

Reset
REQ-033 rst sampled high for one clk edge: state=IDLE, all balances=INIT_BALANCE, ack=0, success=0, balance_out=0, grant_id=0, busy=0, last granted=NUM_TERM-1.
REQ-034 Reset in READ, EXEC or WRITE aborts the transaction: no commit and no ack.

Structure
REQ-035 Package atm_pkg holds the opcode and FSM state enums and the NUM_ACC/INIT_BALANCE defaults.
REQ-036 Sub-module rr_arbiter: input req vector and last-grant pointer; output one-hot grant and binary index.
REQ-037 The balance store is an internal register array, NUM_ACC x 32, with no file I/O.

Verification
REQ-038 After reset, T0 BALANCE acc 3 -> ack[0] 4 cycles after sampling, success=1, balance_out=1000.
REQ-039 T1 WITHDRAW acc 2 amount 300, then T1 BALANCE acc 2 -> balance_out 700, then 700, both success=1.
REQ-040 T2 WITHDRAW acc 5 amount 1001 -> success=0, balance_out=1000; a follow-up BALANCE reads 1000.
REQ-041 All four terminals request DEPOSIT 10 to acc 0 in the same cycle -> acks in order T0, T1, T2, T3, 5 cycles apart, balance_out 1010/1020/1030/1040.
REQ-042 DEPOSIT 0xFFFFFFFF to acc 1 -> success=0, balance stays 1000; acc 12 -> success=0, balance_out=0.
REQ-043 Assert rst in EXEC of a WITHDRAW 500 on acc 4 -> no ack, acc 4 reads 1000 afterwards, busy=0.
